// File: rtl/move_select_pkg.sv
// Shared types and field positions for the move selection stage.
// Locations are {column, row} nibbles; pieces are {side, type}.
package move_select_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOOK_SRC = 3'd1,
      ST_HELD     = 3'd2,
      ST_LOOK_DST = 3'd3,
      ST_ISSUE    = 3'd4
   } state_t;

   localparam int PIECE_SIDE_BIT = 3;
   localparam int PIECE_TYPE_MSB = 2;
   localparam int PIECE_TYPE_LSB = 0;

   localparam logic [3:0] EMPTY = 4'h0;
   localparam logic       RED   = 1'b0;
   localparam logic       BLACK = 1'b1;

   localparam int LOC_COL_MSB = 7;
   localparam int LOC_COL_LSB = 4;
   localparam int LOC_ROW_MSB = 3;
   localparam int LOC_ROW_LSB = 0;

   function automatic logic [3:0] loc_col(input logic [7:0] loc);
      return loc[LOC_COL_MSB:LOC_COL_LSB];
   endfunction

   function automatic logic [3:0] loc_row(input logic [7:0] loc);
      return loc[LOC_ROW_MSB:LOC_ROW_LSB];
   endfunction

   // A square holds a piece of the given side only if its type is nonzero.
   function automatic logic is_own(input logic [3:0] piece,
                                   input logic       side);
      return (piece != EMPTY) &&
             (piece[PIECE_TYPE_MSB:PIECE_TYPE_LSB] != 3'd0) &&
             (piece[PIECE_SIDE_BIT] == side);
   endfunction

endpackage

// File: rtl/loc_range_check.sv
// Combinational check that a {column,row} location lies on the board.
// Both fields are compared unsigned; nothing wraps or clamps.
module loc_range_check
   import move_select_pkg::*;
#(
   parameter int NCOL = 9,
   parameter int NROW = 10
) (
   input  logic [7:0] location,
   output logic       in_range
);

   localparam logic [4:0] NCOL_W = 5'(NCOL);
   localparam logic [4:0] NROW_W = 5'(NROW);

   always_comb begin
      in_range = ({1'b0, loc_col(location)} < NCOL_W) &&
                 ({1'b0, loc_row(location)} < NROW_W);
   end

endmodule

// File: rtl/move_select.sv
// Two-click move selection: pick an own piece, then a destination,
// and hold the resulting move until the board engine accepts it.
module move_select
   import move_select_pkg::*;
#(
   parameter int NCOL = 9,
   parameter int NROW = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] location,
   input  logic       request,
   output logic [7:0] query_addr,
   input  logic [3:0] board_piece,
   output logic       move_valid,
   output logic [7:0] move_src,
   output logic [7:0] move_dst,
   input  logic       move_ack,
   output logic       sel_valid,
   output logic [7:0] sel_loc,
   output logic       turn,
   output logic       err
);

   state_t     state_q, state_d;
   logic [7:0] query_addr_q, query_addr_d;
   logic       move_valid_q, move_valid_d;
   logic [7:0] move_src_q, move_src_d;
   logic [7:0] move_dst_q, move_dst_d;
   logic       sel_valid_q, sel_valid_d;
   logic [7:0] sel_loc_q, sel_loc_d;
   logic       turn_q, turn_d;
   logic       err_q, err_d;
   logic       in_range;
   logic       own_piece;

   loc_range_check #(
      .NCOL (NCOL),
      .NROW (NROW)
   ) u_range (
      .location (location),
      .in_range (in_range)
   );

   assign own_piece = is_own(board_piece, turn_q);

   always_comb begin
      state_d      = state_q;
      query_addr_d = query_addr_q;
      move_valid_d = move_valid_q;
      move_src_d   = move_src_q;
      move_dst_d   = move_dst_q;
      sel_valid_d  = sel_valid_q;
      sel_loc_d    = sel_loc_q;
      turn_d       = turn_q;
      err_d        = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (request) begin
               if (in_range) begin
                  query_addr_d = location;
                  state_d      = ST_LOOK_SRC;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOOK_SRC: begin
            if (own_piece) begin
               sel_loc_d   = query_addr_q;
               sel_valid_d = 1'b1;
               state_d     = ST_HELD;
            end else begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_HELD: begin
            if (request) begin
               if (in_range) begin
                  query_addr_d = location;
                  state_d      = ST_LOOK_DST;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_LOOK_DST: begin
            // Clicking the held square again cancels the selection.
            if (query_addr_q == sel_loc_q) begin
               sel_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else if (own_piece) begin
               sel_loc_d = query_addr_q;
               state_d   = ST_HELD;
            end else begin
               move_src_d   = sel_loc_q;
               move_dst_d   = query_addr_q;
               move_valid_d = 1'b1;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (move_ack) begin
               move_valid_d = 1'b0;
               sel_valid_d  = 1'b0;
               turn_d       = (turn_q == RED) ? BLACK : RED;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         query_addr_q <= 8'h00;
         move_valid_q <= 1'b0;
         move_src_q   <= 8'h00;
         move_dst_q   <= 8'h00;
         sel_valid_q  <= 1'b0;
         sel_loc_q    <= 8'h00;
         turn_q       <= RED;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         query_addr_q <= query_addr_d;
         move_valid_q <= move_valid_d;
         move_src_q   <= move_src_d;
         move_dst_q   <= move_dst_d;
         sel_valid_q  <= sel_valid_d;
         sel_loc_q    <= sel_loc_d;
         turn_q       <= turn_d;
         err_q        <= err_d;
      end
   end

   assign query_addr = query_addr_q;
   assign move_valid = move_valid_q;
   assign move_src   = move_src_q;
   assign move_dst   = move_dst_q;
   assign sel_valid  = sel_valid_q;
   assign sel_loc    = sel_loc_q;
   assign turn       = turn_q;
   assign err        = err_q;

endmodule

// File: tb/tb_move_select.sv
// Directed bench for move_select: select, move, reject, cancel,
// reselect and reset-in-issue sequences with fixed expected values.
module tb_move_select;

   logic       clk;
   logic       rst;
   logic [7:0] location;
   logic       request;
   logic [7:0] query_addr;
   logic [3:0] board_piece;
   logic       move_valid;
   logic [7:0] move_src;
   logic [7:0] move_dst;
   logic       move_ack;
   logic       sel_valid;
   logic [7:0] sel_loc;
   logic       turn;
   logic       err;

   int n_asserts;
   int n_fails;

   move_select #(
      .NCOL (9),
      .NROW (10)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .location    (location),
      .request     (request),
      .query_addr  (query_addr),
      .board_piece (board_piece),
      .move_valid  (move_valid),
      .move_src    (move_src),
      .move_dst    (move_dst),
      .move_ack    (move_ack),
      .sel_valid   (sel_valid),
      .sel_loc     (sel_loc),
      .turn        (turn),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [7:0] obs,
                      input logic [7:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " query_addr"}, query_addr, 8'h00);
      chk({tag, " move_valid"}, {7'd0, move_valid}, 8'h00);
      chk({tag, " move_src"}, move_src, 8'h00);
      chk({tag, " move_dst"}, move_dst, 8'h00);
      chk({tag, " sel_valid"}, {7'd0, sel_valid}, 8'h00);
      chk({tag, " sel_loc"}, sel_loc, 8'h00);
      chk({tag, " turn"}, {7'd0, turn}, 8'h00);
      chk({tag, " err"}, {7'd0, err}, 8'h00);
   endtask

   initial begin
      n_asserts   = 0;
      n_fails     = 0;
      rst         = 1'b1;
      location    = 8'h00;
      request     = 1'b0;
      board_piece = 4'h0;
      move_ack    = 1'b0;
      tick();
      tick();
      chk_reset_vals("reset");
      rst = 1'b0;

      // Select own red piece at 23.
      location = 8'h23;
      request  = 1'b1;
      tick();
      request = 1'b0;
      chk("src query_addr", query_addr, 8'h23);
      chk("src sel_valid early", {7'd0, sel_valid}, 8'h00);
      board_piece = 4'h1;
      tick();
      chk("src sel_valid", {7'd0, sel_valid}, 8'h01);
      chk("src sel_loc", sel_loc, 8'h23);
      chk("src err", {7'd0, err}, 8'h00);

      // Destination 25 empty -> move issued.
      location = 8'h25;
      request  = 1'b1;
      tick();
      request = 1'b0;
      chk("dst query_addr", query_addr, 8'h25);
      board_piece = 4'h0;
      tick();
      chk("issue move_valid", {7'd0, move_valid}, 8'h01);
      chk("issue move_src", move_src, 8'h23);
      chk("issue move_dst", move_dst, 8'h25);

      // Hold without ack; a request in between is dropped.
      for (int i = 0; i < 3; i++) begin
         request  = (i == 1);
         location = 8'h44;
         tick();
         chk("hold move_valid", {7'd0, move_valid}, 8'h01);
         chk("hold move_src", move_src, 8'h23);
         chk("hold move_dst", move_dst, 8'h25);
         chk("hold query_addr", query_addr, 8'h25);
         chk("hold err", {7'd0, err}, 8'h00);
      end

      // Ack together with a request: ack wins.
      move_ack = 1'b1;
      request  = 1'b1;
      location = 8'h11;
      tick();
      move_ack = 1'b0;
      request  = 1'b0;
      chk("ack move_valid", {7'd0, move_valid}, 8'h00);
      chk("ack turn", {7'd0, turn}, 8'h01);
      chk("ack sel_valid", {7'd0, sel_valid}, 8'h00);
      chk("ack query_addr", query_addr, 8'h25);

      // Stray ack in IDLE does nothing.
      move_ack = 1'b1;
      tick();
      move_ack = 1'b0;
      chk("stray ack turn", {7'd0, turn}, 8'h01);
      chk("stray ack move_valid", {7'd0, move_valid}, 8'h00);

      // Back to red to move; black piece at 40 is rejected.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2 turn", {7'd0, turn}, 8'h00);
      location = 8'h40;
      request  = 1'b1;
      tick();
      request     = 1'b0;
      board_piece = 4'h9;
      tick();
      chk("opp err", {7'd0, err}, 8'h01);
      chk("opp sel_valid", {7'd0, sel_valid}, 8'h00);
      tick();
      chk("opp err one cycle", {7'd0, err}, 8'h00);

      // Out-of-range column then row.
      location = 8'h9A;
      request  = 1'b1;
      tick();
      request = 1'b0;
      chk("col oor err", {7'd0, err}, 8'h01);
      chk("col oor query_addr", query_addr, 8'h40);
      tick();
      chk("col oor err clear", {7'd0, err}, 8'h00);
      location = 8'h0A;
      request  = 1'b1;
      tick();
      request = 1'b0;
      chk("row oor err", {7'd0, err}, 8'h01);
      chk("row oor query_addr", query_addr, 8'h40);
      tick();
      chk("row oor err clear", {7'd0, err}, 8'h00);

      // Corner 89 is on the board; empty square rejected after lookup.
      location = 8'h89;
      request  = 1'b1;
      tick();
      request = 1'b0;
      chk("corner query_addr", query_addr, 8'h89);
      chk("corner err", {7'd0, err}, 8'h00);
      board_piece = 4'h0;
      tick();
      chk("empty err", {7'd0, err}, 8'h01);
      chk("empty sel_valid", {7'd0, sel_valid}, 8'h00);

      // Select 23, then click it again to cancel.
      location = 8'h23;
      request  = 1'b1;
      tick();
      request     = 1'b0;
      board_piece = 4'h1;
      tick();
      chk("cancel pre sel_valid", {7'd0, sel_valid}, 8'h01);
      request = 1'b1;
      tick();
      request = 1'b0;
      tick();
      chk("cancel sel_valid", {7'd0, sel_valid}, 8'h00);
      chk("cancel err", {7'd0, err}, 8'h00);

      // Select 23, out-of-range click while held, then reselect 33.
      request = 1'b1;
      tick();
      request = 1'b0;
      tick();
      chk("resel pre sel_loc", sel_loc, 8'h23);
      location = 8'hA0;
      request  = 1'b1;
      tick();
      request = 1'b0;
      chk("held oor err", {7'd0, err}, 8'h01);
      chk("held oor sel_valid", {7'd0, sel_valid}, 8'h01);
      location = 8'h33;
      request  = 1'b1;
      tick();
      request     = 1'b0;
      board_piece = 4'h2;
      chk("held oor err clear", {7'd0, err}, 8'h00);
      tick();
      chk("resel sel_loc", sel_loc, 8'h33);
      chk("resel sel_valid", {7'd0, sel_valid}, 8'h01);
      chk("resel move_valid", {7'd0, move_valid}, 8'h00);

      // Capture black piece at 35, then reset during ISSUE.
      location = 8'h35;
      request  = 1'b1;
      tick();
      request     = 1'b0;
      board_piece = 4'hA;
      tick();
      chk("cap move_valid", {7'd0, move_valid}, 8'h01);
      chk("cap move_src", move_src, 8'h33);
      chk("cap move_dst", move_dst, 8'h35);
      rst      = 1'b1;
      request  = 1'b1;
      location = 8'h44;
      tick();
      rst     = 1'b0;
      request = 1'b0;
      chk_reset_vals("rst issue");
      move_ack = 1'b1;
      tick();
      move_ack = 1'b0;
      tick();
      chk("post rst move_valid", {7'd0, move_valid}, 8'h00);
      chk("post rst turn", {7'd0, turn}, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asserts, n_fails);
      $finish;
   end

endmodule

// File: doc/move_select.md
MOVE_SELECT -- requirements
Module: move_select

Interface
REQ-001 Parameter: NCOL, 9, number of board columns; legal column field is 0..NCOL-1.
REQ-002 Parameter: NROW, 10, number of board rows; legal row field is 0..NROW-1.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  system clock.
REQ-005 Port: rst  input  1  reset.
REQ-006 Port: location  input  8  cursor position from the cursor stage; [7:4] column, [3:0] row.
REQ-007 Port: request  input  1  single-cycle Enter pulse from the cursor stage.
REQ-008 Port: query_addr  output  8  registered board address to read, same format as location.
REQ-009 Port: board_piece  input  4  piece at query_addr; 0 = empty; [3] = side (0 red, 1 black); [2:0] type, nonzero when occupied.
REQ-010 Port: move_valid  output  1  move offered to the board engine.
REQ-011 Port: move_src  output  8  source square of the offered move.
REQ-012 Port: move_dst  output  8  destination square of the offered move.
REQ-013 Port: move_ack  input  1  board engine accepts the move.
REQ-014 Port: sel_valid  output  1  source square currently held, for display highlight.
REQ-015 Port: sel_loc  output  8  held source square.
REQ-016 Port: turn  output  1  side to move; 0 red, 1 black.
REQ-017 Port: err  output  1  single-cycle pulse on a rejected selection.

Function
REQ-018 The FSM SHALL have the states IDLE, LOOK_SRC, HELD, LOOK_DST and ISSUE.
REQ-019 IDLE + request: if location is in range, capture it into query_addr and go to LOOK_SRC; otherwise pulse err and stay in IDLE.
REQ-020 board_piece is valid combinationally from query_addr and SHALL be sampled only in the LOOK_SRC/LOOK_DST cycle, exactly one cycle after the request.
REQ-021 LOOK_SRC, own piece (nonzero, [3]==turn): set sel_loc=query_addr, assert sel_valid, go to HELD.
REQ-022 LOOK_SRC, empty or opponent piece: pulse err, go to IDLE.
REQ-023 HELD + request: an in-range location SHALL go to LOOK_DST with query_addr=location; an out-of-range location SHALL pulse err and stay in HELD.
REQ-024 LOOK_DST, query_addr==sel_loc: cancel; deassert sel_valid, go to IDLE, no err.
REQ-025 LOOK_DST, own piece elsewhere: reselect; sel_loc=query_addr, stay selected, go to HELD.
REQ-026 LOOK_DST, empty or opponent piece: load move_src=sel_loc and move_dst=query_addr, assert move_valid, go to ISSUE.
REQ-027 ISSUE: move_valid, move_src and move_dst SHALL stay stable until a cycle with move_ack=1.
REQ-028 On that ack cycle, the block SHALL at the next edge clear move_valid and sel_valid, toggle turn, and go to IDLE.
REQ-029 move_ack outside ISSUE SHALL be ignored.
REQ-030 A request arriving in LOOK_SRC, LOOK_DST or ISSUE SHALL be dropped silently (no err, no state change).
REQ-031 Request and move_ack in the same ISSUE cycle: the ack is honoured and the request dropped.
REQ-032 Range check: the location is in range iff column < NCOL and row < NROW; no wrap-around or clamping.
REQ-033 All outputs SHALL be registered; err SHALL be high for exactly one cycle per rejection.

Reset
REQ-034 rst=1 at a clock edge SHALL force IDLE, query_addr=0, move_valid=0, move_src=0, move_dst=0, sel_valid=0, sel_loc=0, turn=0 and err=0.
REQ-035 Reset SHALL take priority over every other input.
REQ-036 Reset mid-ISSUE SHALL drop the pending move without requiring an ack.

Structure
REQ-037 The shared package SHALL hold: state encoding, piece field positions, EMPTY=4'h0, side constants RED=0/BLACK=1, and the location field slices.
REQ-038 There SHALL be one sub-module, loc_range_check: combinational location-to-in_range, parameterised by NCOL and NROW.

Verification
REQ-039 Scenario: after reset, turn=0; request at 8'h23, board_piece=4'h1 -> sel_valid=1, sel_loc=8'h23 two cycles after the request.
REQ-040 Scenario: held 8'h23; request at 8'h25, board_piece=4'h0 -> move_valid=1, src=8'h23, dst=8'h25; hold 3 cycles without ack -> outputs stable; move_ack=1 -> move_valid=0 and turn=1 next cycle.
REQ-041 Scenario: turn=0, request at 8'h40 with board_piece=4'h9 (black) -> err high one cycle, state IDLE, sel_valid=0.
REQ-042 Scenario: request at 8'h9A and at 8'h0A -> err pulse each, no query_addr change.
REQ-043 Scenario: held 8'h23; request at 8'h23 -> cancel, sel_valid=0; reselect to 8'h33 holding an own piece -> sel_loc=8'h33.
REQ-044 Scenario: rst asserted in ISSUE with a request in the same cycle -> all outputs at reset values next cycle, no move issued.
